// File: rtl/znake_pkg.sv
// Shared direction definitions for the snake game: 2-bit direction type,
// named direction constants and the opposite-direction helper.
package znake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    // The encoding puts each direction next to its opposite, so flipping bit 0 reverses it.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of directions with occupancy count and a view of the
// most recently written entry (the tail), used by the direction arbiter.
module dir_fifo
    import znake_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  dir_t          data,
    output dir_t          head,
    output dir_t          tail,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    dir_t          mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    // push/pop are one-cycle requests: a pop on an empty FIFO is ignored, and a
    // push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign head = mem[rd_ptr];
    assign tail = mem[wr_ptr - AW'(1)];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/direction_arbiter.sv
// Arbitrates direction-button presses, filters redundant turns and queues them
// until the game-step strobe applies one. Reversal blocking: DIR_REVERSE_BLOCK_EN.
module direction_arbiter
    import znake_pkg::*;
#(
    parameter int   QUEUE_DEPTH = 2,
    parameter dir_t INIT_DIR    = DIR_RIGHT
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [3:0]                   i_press,
    input  logic                         i_tick,
    output dir_t                         o_dir,
    output logic                         o_turn,
    output logic                         o_drop,
    output logic [$clog2(QUEUE_DEPTH):0] o_qcount
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    dir_t          cand;
    logic          cand_valid;
    logic [3:0]    cand_mask;
    logic          lost_arb;
    dir_t          tail_dir;
    logic          same_as_tail;
    logic          reverse_hit;
    logic          blocked_full;
    logic          cand_drop;
    logic          drop_any;
    logic          push;
    logic          pop;

    dir_t          fifo_head;
    dir_t          fifo_tail;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // Press bit index equals the direction code, so the winner maps straight onto dir_t.
    always_comb begin
        cand_valid = |i_press;
        cand       = DIR_RIGHT;
        if (i_press[0]) begin
            cand = DIR_UP;
        end else if (i_press[1]) begin
            cand = DIR_DOWN;
        end else if (i_press[2]) begin
            cand = DIR_LEFT;
        end
        cand_mask = 4'b0001 << cand;
        lost_arb  = |(i_press & ~cand_mask);
    end

    always_comb begin
        tail_dir     = fifo_empty ? o_dir : fifo_tail;
        pop          = i_tick && !fifo_empty && !i_rst;
        same_as_tail = (cand == tail_dir);
        blocked_full = fifo_full && !pop;
`ifdef DIR_REVERSE_BLOCK_EN
        reverse_hit  = (cand == opposite(tail_dir));
`else
        reverse_hit  = 1'b0;
`endif
        cand_drop = cand_valid && (same_as_tail || blocked_full || reverse_hit);
        push      = cand_valid && !cand_drop && !i_rst;
        drop_any  = (lost_arb || cand_drop) && !i_rst;
    end

    dir_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .data  (cand),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_qcount = fifo_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dir  <= INIT_DIR;
            o_turn <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            if (pop) begin
                o_dir <= fifo_head;
            end
            o_turn <= pop;
            o_drop <= drop_any;
        end
    end

endmodule
